// File: rtl/audio_mixer_n.sv
// audio_mixer_n: N-channel stereo mixer with per-channel L/R gains.
// A sample strobe snapshots all channel inputs. Each cycle, one channel is then
// multiplied by its left and right gains and accumulated. The sums are scaled,
// saturated and presented together with a one-cycle out_valid pulse.
// Optional feature: define AUDIO_MIX_PEAK_EN to build the per-side peak-magnitude
// trackers. Without it, peak_l and peak_r are constant zero.

// One mix side: multiplier, accumulator, final scale and saturation.
module audio_mixer_side #(
  parameter int IN_W   = 16,
  parameter int GAIN_W = 8,
  parameter int OUT_W  = 16,
  parameter int ACC_W  = 28
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    step,
  input  logic signed [IN_W-1:0]  smp,
  input  logic [GAIN_W-1:0]       gain,
  input  logic                    en,
  output logic signed [OUT_W-1:0] y,
  output logic                    sat
);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

  logic signed [IN_W+GAIN_W:0] prod;
  logic signed [ACC_W-1:0]     prod_ext, acc, acc_next, shifted;

  // Gain is unsigned, so it is zero-extended before the signed multiply.
  assign prod     = smp * $signed({1'b0, gain});
  assign prod_ext = en ? ACC_W'(prod) : '0;
  assign acc_next = acc + prod_ext;
  // Drop the Q2 fraction. Arithmetic shift rounds toward -inf.
  assign shifted  = acc_next >>> (GAIN_W-2);

  // Clamp the scaled sum to the output range.
  always_comb begin
    sat = 1'b0;
    y   = shifted[OUT_W-1:0];
    if (shifted > MAXV) begin
      y   = MAXV[OUT_W-1:0];
      sat = 1'b1;
    end else if (shifted < MINV) begin
      y   = MINV[OUT_W-1:0];
      sat = 1'b1;
    end
  end

  // Accumulator: cleared at the start of a mix, then advanced once per channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     acc <= '0;
    else if (clr)  acc <= '0;
    else if (step) acc <= acc_next;
  end
endmodule

module audio_mixer_n #(
  parameter int CHANNELS = 4,
  parameter int IN_W     = 16,
  parameter int GAIN_W   = 8,
  parameter int OUT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_in,
  input  logic [CHANNELS*IN_W-1:0]   ch_in,
  input  logic [CHANNELS-1:0]        ch_en,
  input  logic [CHANNELS*GAIN_W-1:0] gain_l,
  input  logic [CHANNELS*GAIN_W-1:0] gain_r,
  output logic signed [OUT_W-1:0]    out_l,
  output logic signed [OUT_W-1:0]    out_r,
  output logic                       out_valid,
  output logic                       clip,
  output logic                       busy,
  output logic                       overrun,
  output logic [OUT_W-2:0]           peak_l,
  output logic [OUT_W-2:0]           peak_r,
  input  logic                       peak_clr
);
  localparam int ACC_W = IN_W + GAIN_W + 1 + $clog2(CHANNELS) + 1;
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
  state_t state, state_n;

  logic [CHANNELS-1:0][IN_W-1:0]   snap_s;
  logic [CHANNELS-1:0][GAIN_W-1:0] snap_gl, snap_gr;
  logic [CHANNELS-1:0]             snap_en;
  logic [IDX_W-1:0]                idx;
  logic                            start, step, last;
  logic [1:0][OUT_W-1:0]           y_side;
  logic [1:0]                      sat_side;

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and per-cycle controls. The final ACC cycle also loads the outputs,
  // so out_valid lines up with the OUT state.
  always_comb begin
    state_n = state;
    start   = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: if (sample_in) begin
        start   = 1'b1;
        state_n = ACC;
      end
      ACC: begin
        step = 1'b1;
        if (idx == IDX_W'(CHANNELS-1)) begin
          last    = 1'b1;
          state_n = OUT;
        end
      end
      OUT:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Snapshot the inputs on an accepted strobe and advance the channel index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_s  <= '0;
      snap_gl <= '0;
      snap_gr <= '0;
      snap_en <= '0;
      idx     <= '0;
    end else if (start) begin
      snap_s  <= ch_in;
      snap_gl <= gain_l;
      snap_gr <= gain_r;
      snap_en <= ch_en;
      idx     <= '0;
    end else if (step) begin
      idx     <= idx + 1'b1;
    end
  end

  // Side 0 is left, side 1 is right. Both share the current channel sample.
  for (genvar s = 0; s < 2; s++) begin : g_side
    audio_mixer_side #(
      .IN_W(IN_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W), .ACC_W(ACC_W)
    ) u_side (
      .clk  (clk),
      .reset(reset),
      .clr  (start),
      .step (step),
      .smp  ($signed(snap_s[idx])),
      .gain ((s == 0) ? snap_gl[idx] : snap_gr[idx]),
      .en   (snap_en[idx]),
      .y    (y_side[s]),
      .sat  (sat_side[s])
    );
  end

  // Output registers. out_valid and clip are one-cycle pulses; samples hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      clip      <= 1'b0;
    end else begin
      out_valid <= last;
      clip      <= last & (sat_side[0] | sat_side[1]);
      if (last) begin
        out_l <= $signed(y_side[0]);
        out_r <= $signed(y_side[1]);
      end
    end
  end

  // Sticky flag: a strobe that arrived while a mix was in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     overrun <= 1'b0;
    else if (sample_in && busy)    overrun <= 1'b1;
  end

`ifdef AUDIO_MIX_PEAK_EN
  function automatic logic [OUT_W-2:0] mag(input logic signed [OUT_W-1:0] v);
    logic signed [OUT_W-1:0] n;
    n = -v;
    if (!v[OUT_W-1])                        return v[OUT_W-2:0];
    if (v == {1'b1, {(OUT_W-1){1'b0}}})     return {(OUT_W-1){1'b1}};
    return n[OUT_W-2:0];
  endfunction

  logic [OUT_W-2:0] mag_l, mag_r;
  assign mag_l = mag(out_l);
  assign mag_r = mag(out_r);

  // Peak tracking. A clear that coincides with a new sample restarts from that sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_l <= '0;
      peak_r <= '0;
    end else if (out_valid) begin
      peak_l <= (peak_clr || mag_l > peak_l) ? mag_l : peak_l;
      peak_r <= (peak_clr || mag_r > peak_r) ? mag_r : peak_r;
    end else if (peak_clr) begin
      peak_l <= '0;
      peak_r <= '0;
    end
  end
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak_l = '0;
  assign peak_r = '0;
`endif
endmodule

// File: tb/tb_audio_mixer_n.sv
// Scoreboard bench for audio_mixer_n. Stimulus pushes expected mixes; a monitor checks them.
module tb_audio_mixer_n;
  localparam int CH = 4, IN_W = 16, GAIN_W = 8, OUT_W = 16, LAT = CH + 1;

  logic clk = 1'b0, reset = 1'b1;
  logic sample_in = 1'b0, peak_clr = 1'b0;
  logic [CH*IN_W-1:0]   ch_in = '0;
  logic [CH-1:0]        ch_en = '0;
  logic [CH*GAIN_W-1:0] gain_l = '0, gain_r = '0;
  logic signed [OUT_W-1:0] out_l, out_r;
  logic out_valid, clip, busy, overrun;
  logic [OUT_W-2:0] peak_l, peak_r;

  audio_mixer_n #(.CHANNELS(CH), .IN_W(IN_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .ch_in(ch_in), .ch_en(ch_en),
    .gain_l(gain_l), .gain_r(gain_r), .out_l(out_l), .out_r(out_r), .out_valid(out_valid),
    .clip(clip), .busy(busy), .overrun(overrun), .peak_l(peak_l), .peak_r(peak_r),
    .peak_clr(peak_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { longint l; longint r; bit clip; int at; } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int last_acc = -100;
  bit exp_ovr = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference mix: the exact integer sum, floor-divided by unity gain, then clamped.
  function automatic exp_t model(input logic [CH*IN_W-1:0] s, input logic [CH-1:0] en,
                                 input logic [CH*GAIN_W-1:0] gl, input logic [CH*GAIN_W-1:0] gr);
    longint al = 0, ar = 0, yl, yr, hi, lo;
    exp_t e;
    hi = (longint'(1) << (OUT_W-1)) - 1;
    lo = -hi - 1;
    for (int i = 0; i < CH; i++) begin
      if (en[i]) begin
        longint smp;
        smp = longint'($signed(s[i*IN_W +: IN_W]));
        al += smp * longint'(gl[i*GAIN_W +: GAIN_W]);
        ar += smp * longint'(gr[i*GAIN_W +: GAIN_W]);
      end
    end
    yl = (al >= 0) ? al / 64 : -((-al + 63) / 64);
    yr = (ar >= 0) ? ar / 64 : -((-ar + 63) / 64);
    e.clip = (yl > hi) || (yl < lo) || (yr > hi) || (yr < lo);
    e.l = (yl > hi) ? hi : (yl < lo) ? lo : yl;
    e.r = (yr > hi) ? hi : (yr < lo) ? lo : yr;
    e.at = 0;
    return e;
  endfunction

  function automatic logic [CH*IN_W-1:0] pk_s(input int a, input int b, input int c, input int d);
    return {IN_W'(d), IN_W'(c), IN_W'(b), IN_W'(a)};
  endfunction
  function automatic logic [CH*GAIN_W-1:0] pk_g(input int a, input int b, input int c, input int d);
    return {GAIN_W'(d), GAIN_W'(c), GAIN_W'(b), GAIN_W'(a)};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle strobe. A mix is expected only when the mixer is idle. The inputs are
  // scrambled afterwards, so that any use of live inputs instead of the snapshot shows up.
  task automatic strobe(input logic [CH*IN_W-1:0] s, input logic [CH-1:0] en,
                        input logic [CH*GAIN_W-1:0] gl, input logic [CH*GAIN_W-1:0] gr);
    exp_t e;
    ch_in = s; ch_en = en; gain_l = gl; gain_r = gr; sample_in = 1'b1;
    if (cyc >= last_acc + CH + 2) begin
      e = model(s, en, gl, gr);
      e.at = cyc + LAT;
      q.push_back(e);
      last_acc = cyc;
    end else begin
      exp_ovr = 1'b1;
    end
    idle(1);
    sample_in = 1'b0;
    ch_in = {$urandom(), $urandom()};
    ch_en = CH'($urandom());
    gain_l = $urandom();
    gain_r = $urandom();
  endtask

  // Monitor: compares every out_valid against the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_valid: got out_valid=1 expected none (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("out_l", out_l, e.l);
          check("out_r", out_r, e.r);
          check("clip", clip, e.clip);
          check("latency", cyc, e.at);
        end
      end else begin
        check("clip_idle", clip, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_l", out_l, 0);
    check("rst_out_r", out_r, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_peak_l", peak_l, 0);
    idle(1);

    // Unity gain on a single channel. busy rises after the strobe.
    strobe(pk_s(1000, 7, 7, 7), 4'b0001, pk_g(64, 9, 9, 9), pk_g(64, 9, 9, 9));
    @(negedge clk);
    check("busy_run", busy, 1);
    idle(LAT + 1);
    // Two channels with unequal left and right gains.
    strobe(pk_s(1000, -500, 3, 3), 4'b0011, pk_g(128, 64, 1, 1), pk_g(32, 64, 1, 1));
    idle(LAT + 1);
    // Positive and negative saturation.
    strobe(pk_s(30000, 30000, 30000, 30000), 4'b1111, pk_g(255, 255, 255, 255), pk_g(255, 255, 255, 255));
    idle(LAT + 1);
    strobe(pk_s(-32768, -32768, -32768, -32768), 4'b1111, pk_g(255, 255, 255, 255), pk_g(255, 255, 255, 255));
    idle(LAT + 1);
    @(negedge clk);
    check("overrun_clear", overrun, 0);
    idle(1);

    // A strobe while busy is ignored, and the next one at the minimum period is accepted.
    strobe(pk_s(111, 222, 333, 444), 4'b1111, pk_g(64, 64, 64, 64), pk_g(10, 20, 30, 40));
    idle(2);
    strobe(pk_s(5, 5, 5, 5), 4'b1111, pk_g(1, 1, 1, 1), pk_g(1, 1, 1, 1));
    idle(2);
    strobe(pk_s(-1, -2, -3, -4), 4'b1010, pk_g(200, 100, 50, 25), pk_g(3, 6, 9, 12));
    idle(LAT + 1);
    @(negedge clk);
    check("overrun_sticky", overrun, exp_ovr);
    idle(1);

    // Reset during a mix aborts the mix without an out_valid pulse.
    strobe(pk_s(2000, 0, 0, 0), 4'b0001, pk_g(64, 0, 0, 0), pk_g(64, 0, 0, 0));
    idle(1);
    reset = 1'b1;
    q.delete();
    exp_ovr = 1'b0;
    last_acc = -100;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_out_l", out_l, 0);
    check("abort_out_r", out_r, 0);
    check("abort_overrun", overrun, 0);
    idle(1);
    reset = 1'b0;
    idle(LAT + 2);
    strobe(pk_s(-700, 300, 0, 0), 4'b0011, pk_g(64, 64, 0, 0), pk_g(100, 17, 0, 0));
    idle(LAT + 1);

`ifdef AUDIO_MIX_PEAK_EN
    peak_clr = 1'b1; idle(1); peak_clr = 1'b0;
    strobe(pk_s(1000, 0, 0, 0), 4'b0001, pk_g(64, 0, 0, 0), pk_g(64, 0, 0, 0));
    idle(LAT + 1);
    strobe(pk_s(-20000, 0, 0, 0), 4'b0001, pk_g(64, 0, 0, 0), pk_g(64, 0, 0, 0));
    idle(LAT + 1);
    strobe(pk_s(500, 0, 0, 0), 4'b0001, pk_g(64, 0, 0, 0), pk_g(64, 0, 0, 0));
    idle(LAT + 2);
    @(negedge clk);
    check("peak_l", peak_l, 20000);
    check("peak_r", peak_r, 20000);
    idle(1);
    peak_clr = 1'b1; idle(1); peak_clr = 1'b0;
    @(negedge clk);
    check("peak_cleared", peak_l, 0);
    idle(1);
    strobe(pk_s(-32768, 0, 0, 0), 4'b0001, pk_g(64, 0, 0, 0), pk_g(64, 0, 0, 0));
    idle(LAT + 2);
    @(negedge clk);
    check("peak_min_clamp", peak_l, 32767);
    idle(1);
`else
    @(negedge clk);
    check("peak_l_off", peak_l, 0);
    check("peak_r_off", peak_r, 0);
    idle(1);
`endif

    // Random traffic. Some gaps are short enough to hit the busy window.
    for (int i = 0; i < 60; i++) begin
      strobe({$urandom(), $urandom()}, CH'($urandom()), $urandom(), $urandom());
      idle($urandom_range(0, 8));
    end
    idle(LAT + 3);
    @(negedge clk);
    check("overrun_final", overrun, exp_ovr);
    check("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
